// File: rtl/mem_arb_pkg.sv
// Shared types and MemRead/MemWrite code constants for the memory port arbiter.
package mem_arb_pkg;

  localparam logic [2:0] MEMREAD_NONE  = 3'b101;
  localparam logic [1:0] MEMWRITE_NONE = 2'b11;
  localparam logic [2:0] MEMREAD_WORD  = 3'b000;

  typedef enum logic [1:0] {
    StIdle,
    StIfBusy,
    StDmBusy
  } arb_state_e;

  // A data-side request is live whenever either code differs from its "none" value.
  function automatic logic dm_pending(input logic [2:0] memread, input logic [1:0] memwrite);
    return (memread != MEMREAD_NONE) || (memwrite != MEMWRITE_NONE);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave is the arbiter's view,
// master the surrounding system's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic [2:0]        dm_memread;
  logic [1:0]        dm_memwrite;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_memread;
  logic [1:0]        mem_memwrite;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;
  logic              err;

  modport slave (
    input  if_req, if_addr, dm_memread, dm_memwrite, dm_addr, dm_wdata, mem_ready, mem_rdata,
    output if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_addr, mem_memread,
           mem_memwrite, mem_wdata, stall_if, stall_mem, err
  );

  modport master (
    output if_req, if_addr, dm_memread, dm_memwrite, dm_addr, dm_wdata, mem_ready, mem_rdata,
    input  if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_addr, mem_memread,
           mem_memwrite, mem_wdata, stall_if, stall_mem, err
  );

endinterface

// File: rtl/mem_arb_wdog.sv
// Busy-cycle watchdog: flags expiry once TIMEOUT consecutive busy cycles passed without
// mem_ready. A ready arriving in the expiry cycle wins over the abort.
module mem_arb_wdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic mem_ready,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 2);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired = busy & ~mem_ready & (cnt_q == CntW'(TIMEOUT));

  always_comb begin
    cnt_d = '0;
    if (busy && !mem_ready && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master (fetch/data) arbiter onto one memory port with data priority and fetch
// anti-starvation. Define MEM_ARB_TIMEOUT_EN to build in the busy-cycle watchdog abort.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 2);

  arb_state_e        state_q;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [2:0]        mem_memread_q;
  logic [1:0]        mem_memwrite_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [StarveW-1:0] starve_q;

  logic              dm_pend;
  logic              starved;
  logic              grant_if;
  logic              grant_dm;
  logic              busy;
  logic              expired;
  logic              done;
  logic [DATA_W-1:0] rdata_out;

  assign dm_pend  = dm_pending(bus.dm_memread, bus.dm_memwrite);
  assign starved  = (starve_q == StarveW'(STARVE_LIMIT));
  assign grant_if = (state_q == StIdle) && bus.if_req && (!dm_pend || starved);
  assign grant_dm = (state_q == StIdle) && dm_pend && !grant_if;
  assign busy     = (state_q != StIdle);
  assign done     = busy && (bus.mem_ready || expired);

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .busy      (busy),
    .mem_ready (bus.mem_ready),
    .expired   (expired)
  );
  assign bus.err = expired & ~reset;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expired        = 1'b0;
  assign bus.err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_memread_q  <= MEMREAD_NONE;
      mem_memwrite_q <= MEMWRITE_NONE;
      starve_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_if) begin
            state_q        <= StIfBusy;
            mem_req_q      <= 1'b1;
            mem_addr_q     <= bus.if_addr;
            mem_memread_q  <= MEMREAD_WORD;
            mem_memwrite_q <= MEMWRITE_NONE;
            starve_q       <= '0;
          end else if (grant_dm) begin
            state_q        <= StDmBusy;
            mem_req_q      <= 1'b1;
            mem_addr_q     <= bus.dm_addr;
            mem_memread_q  <= bus.dm_memread;
            mem_memwrite_q <= bus.dm_memwrite;
            mem_wdata_q    <= bus.dm_wdata;
            // Only data grants that actually made fetch wait count towards starvation.
            if (bus.if_req && !starved) begin
              starve_q <= starve_q + 1'b1;
            end
          end
        end
        StIfBusy, StDmBusy: begin
          if (done) begin
            state_q        <= StIdle;
            mem_req_q      <= 1'b0;
            mem_memread_q  <= MEMREAD_NONE;
            mem_memwrite_q <= MEMWRITE_NONE;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rdata_out = expired ? '0 : bus.mem_rdata;

  assign bus.if_valid = ~reset & (state_q == StIfBusy) & done;
  assign bus.dm_valid = ~reset & (state_q == StDmBusy) & done;
  assign bus.if_rdata = bus.if_valid ? rdata_out : '0;
  assign bus.dm_rdata = bus.dm_valid ? rdata_out : '0;

  assign bus.stall_if  = bus.if_req & ~bus.if_valid;
  assign bus.stall_mem = dm_pend & ~bus.dm_valid;

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_memread  = mem_memread_q;
  assign bus.mem_memwrite = mem_memwrite_q;
  assign bus.mem_wdata    = mem_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data-side grants allowed before fetch is forced.
- TIMEOUT, 16, busy cycles before the watchdog aborts.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request, held until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data.
- if_valid  out  1  fetch completion.
- dm_memread  in  3  MemRead code from Controller; 3'b101 = none.
- dm_memwrite  in  2  MemWrite code from Controller; 2'b11 = none.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data.
- dm_valid  out  1  data completion (load or store).
- mem_req  out  1  memory request.
- mem_addr  out  ADDR_W  memory address.
- mem_memread  out  3  memory MemRead code.
- mem_memwrite  out  2  memory MemWrite code.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory completion.
- mem_rdata  in  DATA_W  memory read data.
- stall_if  out  1  fetch stall.
- stall_mem  out  1  MEM-stage stall.
- err  out  1  one-cycle watchdog-abort pulse.
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high, named reset.

Function
REQ-004 A data request SHALL be pending when dm_memread != 3'b101 or dm_memwrite != 2'b11.
REQ-005 The FSM SHALL have states IDLE, IF_BUSY and DM_BUSY.
REQ-006 In IDLE with a pending request, the block SHALL register address, codes and wdata into the mem_* outputs and move to the owner's BUSY state on the next edge.
REQ-007 Arbitration SHALL give the data side priority, except that when starve_cnt == STARVE_LIMIT and if_req=1, fetch SHALL win.
REQ-008 starve_cnt SHALL increment on each data grant made while if_req=1, SHALL clear on any fetch grant, and SHALL saturate at STARVE_LIMIT.
REQ-009 A fetch grant SHALL drive mem_memread=3'b000 and mem_memwrite=2'b11.
REQ-010 In either BUSY state, mem_req SHALL be 1 and the mem_* outputs SHALL be held stable.
REQ-011 In a BUSY state with mem_ready=1, the owner's valid SHALL be asserted combinationally that cycle with rdata=mem_rdata, and the FSM SHALL return to IDLE.
REQ-012 Minimum latency SHALL be 2 cycles, request to valid; back-to-back throughput SHALL be one transaction per 2 cycles.
REQ-013 stall_if SHALL equal if_req & ~if_valid, and stall_mem SHALL equal data-pending & ~dm_valid.
REQ-014 When no transaction is in progress, mem_memread SHALL be 3'b101 and mem_memwrite SHALL be 2'b11.
REQ-015 If requests are dropped while in IDLE, no grant SHALL occur; requests dropped mid-BUSY SHALL NOT cancel the transaction.
REQ-016 If both sides request in the same IDLE cycle, exactly one grant SHALL be made; the loser SHALL stay stalled.

Reset
REQ-017 While reset=1 at a clk edge, the block SHALL load state=IDLE, mem_req=0, mem_addr=0, mem_wdata=0, mem_memread=3'b101, mem_memwrite=2'b11, starve_cnt=0 and wait counter=0.
REQ-018 While reset=1, if_valid, dm_valid and err SHALL be 0.
REQ-019 Reset during BUSY SHALL abandon the transaction with no valid pulse.

Configuration
REQ-020 With MEM_ARB_TIMEOUT_EN defined, the wait counter SHALL count BUSY cycles without mem_ready.
REQ-021 With MEM_ARB_TIMEOUT_EN defined and the count at TIMEOUT, the block SHALL pulse the owner's valid and err for one cycle with rdata=0 and return to IDLE.
REQ-022 Without MEM_ARB_TIMEOUT_EN, the block SHALL wait indefinitely and err SHALL be tied to 0; the port SHALL exist in both builds.

Structure
REQ-023 Package mem_arb_pkg SHALL hold the state enum and the constants MEMREAD_NONE=3'b101, MEMWRITE_NONE=2'b11 and MEMREAD_WORD=3'b000.
REQ-024 The watchdog SHALL be a sub-module, mem_arb_wdog, instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-025 The bench SHALL cover:
- if_req=1, if_addr=0x40, mem_ready high on the 1st BUSY cycle, mem_rdata=0x00500093 -> if_valid at cycle 1 with if_rdata=0x00500093.
- Simultaneous if_req and dm_memread=3'b000 at 0x100 -> data granted first; fetch granted on the next IDLE.
- Continuous data requests with if_req held -> fetch granted after exactly 4 data grants.
- Store dm_memwrite=2'b10, dm_addr=0x8, dm_wdata=0xAB -> mem_memwrite=2'b10 stable until mem_ready, then dm_valid=1.
- reset asserted in DM_BUSY -> next cycle mem_req=0, mem_memread=3'b101, no dm_valid.
- With MEM_ARB_TIMEOUT_EN, mem_ready held 0 -> after 16 BUSY cycles err=1, dm_valid=1, dm_rdata=0.
